flat_shader: RTL and testbench

Per-triangle flat-shading stage of the rasterizer front end. Walks triangle indices 0..N-1, reading each face normal from the normal store and the base colour from the colour store. Computes a clamped Lambert intensity against a light direction plus ambient, scales the RGB565 colour, and writes the result into the shaded-colour store. Runs once per frame, after geometry load and ahead of projection and rasterization.

---
 rtl/flat_shader.sv | 169 ++++++++++++++++
 tb/tb_flat_shader.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flat_shader.sv
// Per-triangle flat shading: Lambert intensity (N.L, clamped) plus ambient scales RGB565 base colour.
// Latency: read_addr for triangle i in cycle 1+i after start, shaded write for i in cycle 5+i, done in 5+N.
// No backpressure: one triangle per cycle; the shaded-colour store must accept every write strobe.
module flat_shader #(
    parameter int ADDR_W = 12,
    parameter int COMP_W = 18
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_W:0]       num_tris,
    input  logic [3*COMP_W-1:0]   light_dir,
    input  logic [7:0]            ambient,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W-1:0]     read_addr,
    input  logic [3*COMP_W-1:0]   normal_q,
    input  logic [15:0]           color_q,
    output logic                  shade_we,
    output logic [ADDR_W-1:0]     shade_addr,
    output logic [15:0]           shade_data
);

    localparam int PW = 2 * COMP_W;     // product width, Q4.32
    localparam int SW = PW + 2;         // dot-product sum width, Q6.32
    localparam logic [ADDR_W:0] IDX_ONE = 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                state, state_nx;
    logic [ADDR_W:0]       idx;
    logic [ADDR_W:0]       n_reg;
    logic [3*COMP_W-1:0]   light_reg;
    logic [7:0]            amb_reg;

    // pipeline valid bits and carried indices
    logic                  v1, v2, v3;
    logic [ADDR_W-1:0]     i1, i2, i3;

    // S2 registers
    logic signed [PW-1:0]  p_x, p_y, p_z;
    logic [15:0]           c2;

    // S3 registers
    logic [8:0]            t3;
    logic [15:0]           c3;

    // combinational helpers
    logic signed [COMP_W-1:0] nx, ny, nz, lx, ly, lz;
    logic signed [SW-1:0]     d_sum;
    logic [8:0]               intensity;
    logic [9:0]               amb_plus_i;
    logic [8:0]               t_nx;
    logic [15:0]              r_prod, g_prod, b_prod;
    logic [15:0]              shaded_nx;

    assign busy      = (state == RUN) || (state == DRAIN);
    assign done      = (state == DONE);
    assign read_addr = idx[ADDR_W-1:0];

    // Next-state logic: RUN issues one index per cycle, DRAIN waits for the pipe to empty
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (start) state_nx = (num_tris == '0) ? DONE : RUN;
            RUN:   if (idx == n_reg - IDX_ONE) state_nx = DRAIN;
            DRAIN: if (!(v1 || v2 || v3)) state_nx = DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register, per-pass latches and the read index counter
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            n_reg     <= '0;
            light_reg <= '0;
            amb_reg   <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                n_reg     <= num_tris;
                light_reg <= light_dir;
                amb_reg   <= ambient;
                idx       <= '0;
            end else if (state == RUN) begin
                idx <= idx + IDX_ONE;
            end
        end
    end

    // Valid bits walk the pipe; reset kills everything in flight so no write follows it
    always_ff @(posedge clock) begin
        if (reset) begin
            v1       <= 1'b0;
            v2       <= 1'b0;
            v3       <= 1'b0;
            shade_we <= 1'b0;
        end else begin
            v1       <= (state == RUN);
            v2       <= v1;
            v3       <= v2;
            shade_we <= v3;
        end
    end

    // Unpack the face normal (from RAM) and the latched light vector
    always_comb begin
        nx = normal_q[3*COMP_W-1:2*COMP_W];
        ny = normal_q[2*COMP_W-1:COMP_W];
        nz = normal_q[COMP_W-1:0];
        lx = light_reg[3*COMP_W-1:2*COMP_W];
        ly = light_reg[2*COMP_W-1:COMP_W];
        lz = light_reg[COMP_W-1:0];
    end

    // S1 -> S2: full-width signed component products
    always_ff @(posedge clock) begin
        i1  <= idx[ADDR_W-1:0];
        p_x <= PW'(nx) * PW'(lx);
        p_y <= PW'(ny) * PW'(ly);
        p_z <= PW'(nz) * PW'(lz);
        c2  <= color_q;
        i2  <= i1;
    end

    // Dot product, clamp to [0,1.0] as an 8.8 intensity, add ambient and saturate at 256
    always_comb begin
        d_sum = {{2{p_x[PW-1]}}, p_x} + {{2{p_y[PW-1]}}, p_y} + {{2{p_z[PW-1]}}, p_z};
        if (d_sum[SW-1] || (d_sum == '0)) begin
            intensity = 9'd0;
        end else if (d_sum[SW-2:32] != '0) begin
            intensity = 9'd256;
        end else begin
            intensity = {1'b0, d_sum[31:24]};
        end
        amb_plus_i = {2'b00, amb_reg} + {1'b0, intensity};
        t_nx       = (amb_plus_i > 10'd256) ? 9'd256 : amb_plus_i[8:0];
    end

    // S2 -> S3: register the total light factor T
    always_ff @(posedge clock) begin
        t3 <= t_nx;
        c3 <= c2;
        i3 <= i2;
    end

    // Scale each colour channel by T/256; T = 256 returns the channel unchanged
    always_comb begin
        r_prod    = 16'(c3[15:11]) * 16'(t3);
        g_prod    = 16'(c3[10:5])  * 16'(t3);
        b_prod    = 16'(c3[4:0])   * 16'(t3);
        shaded_nx = ((r_prod >> 8) << 11) | ((g_prod >> 8) << 5) | (b_prod >> 8);
    end

    // S3 -> S4: write port registers, only updated for valid triangles
    always_ff @(posedge clock) begin
        if (reset) begin
            shade_addr <= '0;
            shade_data <= '0;
        end else if (v3) begin
            shade_addr <= i3;
            shade_data <= shaded_nx;
        end
    end

endmodule

// File: tb/tb_flat_shader.sv
module tb_flat_shader;

    localparam int AW = 12;
    localparam int CW = 18;

    logic               clock = 1'b0;
    logic               reset;
    logic               start;
    logic [AW:0]        num_tris;
    logic [3*CW-1:0]    light_dir;
    logic [7:0]         ambient;
    logic               busy;
    logic               done;
    logic [AW-1:0]      read_addr;
    logic [3*CW-1:0]    normal_q;
    logic [15:0]        color_q;
    logic               shade_we;
    logic [AW-1:0]      shade_addr;
    logic [15:0]        shade_data;

    always #5 clock = ~clock;

    flat_shader #(.ADDR_W(AW), .COMP_W(CW)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .num_tris   (num_tris),
        .light_dir  (light_dir),
        .ambient    (ambient),
        .busy       (busy),
        .done       (done),
        .read_addr  (read_addr),
        .normal_q   (normal_q),
        .color_q    (color_q),
        .shade_we   (shade_we),
        .shade_addr (shade_addr),
        .shade_data (shade_data)
    );

    // normal and colour stores, one-cycle read latency
    logic signed [CW-1:0] mnx [4096];
    logic signed [CW-1:0] mny [4096];
    logic signed [CW-1:0] mnz [4096];
    logic [15:0]          mcol [4096];

    always @(posedge clock) begin
        normal_q <= {mnx[read_addr], mny[read_addr], mnz[read_addr]};
        color_q  <= mcol[read_addr];
    end

    int cyc = 0;
    int c0  = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // observed behaviour of the current pass, cycle numbers relative to the start cycle
    int wr_addr[$];
    int wr_data[$];
    int wr_cyc[$];
    int done_cnt, done_cyc, busy_cnt, busy_first;

    always @(negedge clock) begin
        if (shade_we === 1'b1) begin
            wr_addr.push_back(int'(shade_addr));
            wr_data.push_back(int'(shade_data));
            wr_cyc.push_back(cyc - c0);
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc - c0;
        end
        if (busy === 1'b1) begin
            if (busy_cnt == 0) busy_first = cyc - c0;
            busy_cnt++;
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // light / ambient of the pass being checked
    logic signed [CW-1:0] cur_lx, cur_ly, cur_lz;
    int cur_amb;

    function automatic int model(input int k);
        longint d;
        int     i, t, r, g, b;
        d = longint'(mnx[k]) * longint'(cur_lx) + longint'(mny[k]) * longint'(cur_ly)
          + longint'(mnz[k]) * longint'(cur_lz);
        if (d <= 0)                     i = 0;
        else if (d >= 64'sd4294967296)  i = 256;
        else                            i = int'(d / 16777216);
        t = cur_amb + i;
        if (t > 256) t = 256;
        r = (int'(mcol[k][15:11]) * t) / 256;
        g = (int'(mcol[k][10:5])  * t) / 256;
        b = (int'(mcol[k][4:0])   * t) / 256;
        return r * 2048 + g * 32 + b;
    endfunction

    task automatic clear_obs();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        done_cnt   = 0;
        done_cyc   = -1;
        busy_cnt   = 0;
        busy_first = -1;
    endtask

    // start pulse in cycle 0; pass inputs are scrambled afterwards to prove they were latched
    task automatic start_pass(input int n, input logic signed [CW-1:0] lx, ly, lz, input int amb);
        @(negedge clock);
        clear_obs();
        cur_lx    = lx;
        cur_ly    = ly;
        cur_lz    = lz;
        cur_amb   = amb;
        num_tris  = (AW+1)'(n);
        light_dir = {lx, ly, lz};
        ambient   = 8'(amb);
        start     = 1'b1;
        c0        = cyc;
        @(negedge clock);
        start     = 1'b0;
        light_dir = ~light_dir;
        ambient   = ~ambient;
    endtask

    task automatic wait_done(input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clock);
            #1;
            if (done_cnt > 0) break;
        end
        repeat (3) @(negedge clock);
        #1;
    endtask

    task automatic verify(input string tag, input int n, input bit use_exp, input int exp_data);
        check({tag, " writes"}, wr_addr.size(), n);
        check({tag, " done_cnt"}, done_cnt, 1);
        check({tag, " done_cyc"}, done_cyc, (n == 0) ? 1 : 5 + n);
        check({tag, " busy_cnt"}, busy_cnt, (n == 0) ? 0 : 4 + n);
        if (n > 0) check({tag, " busy_first"}, busy_first, 1);
        for (int k = 0; k < wr_addr.size() && k < n; k++) begin
            check($sformatf("%s addr[%0d]", tag, k), wr_addr[k], k);
            check($sformatf("%s wcyc[%0d]", tag, k), wr_cyc[k], 5 + k);
            check($sformatf("%s data[%0d]", tag, k), wr_data[k], use_exp ? exp_data : model(k));
        end
    endtask

    // random mostly-unit normals: axis, planar diagonal (0.7071) or body diagonal (0.5774)
    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) begin
            int kind;
            kind = int'($urandom_range(0, 2));
            mnx[i] = '0;
            mny[i] = '0;
            mnz[i] = '0;
            if (kind == 0) begin
                case ($urandom_range(0, 2))
                    0: mnx[i] = $urandom_range(0, 1) ? -18'sd65536 : 18'sd65536;
                    1: mny[i] = $urandom_range(0, 1) ? -18'sd65536 : 18'sd65536;
                    default: mnz[i] = $urandom_range(0, 1) ? -18'sd65536 : 18'sd65536;
                endcase
            end else if (kind == 1) begin
                mnx[i] = $urandom_range(0, 1) ? -18'sd46341 : 18'sd46341;
                mnz[i] = $urandom_range(0, 1) ? -18'sd46341 : 18'sd46341;
            end else begin
                mnx[i] = $urandom_range(0, 1) ? -18'sd37837 : 18'sd37837;
                mny[i] = $urandom_range(0, 1) ? -18'sd37837 : 18'sd37837;
                mnz[i] = $urandom_range(0, 1) ? -18'sd37837 : 18'sd37837;
            end
            mcol[i] = 16'($urandom);
        end
    endtask

    typedef struct {
        logic signed [CW-1:0] nx, ny, nz, lx, ly, lz;
        logic [15:0]          col;
        logic [7:0]           amb;
        logic [15:0]          exp;
    } vec_t;

    vec_t vt[11];

    initial begin
        // single-triangle vectors with hand-computed results
        vt[0]  = '{18'sd0, 18'sd0, 18'sd65536, 18'sd0, 18'sd0, 18'sd65536, 16'hFFFF, 8'd0, 16'hFFFF};
        vt[1]  = '{18'sd0, 18'sd0, -18'sd65536, 18'sd0, 18'sd0, 18'sd65536, 16'hFFFF, 8'd0, 16'h0000};
        vt[2]  = '{18'sd0, 18'sd0, -18'sd65536, 18'sd0, 18'sd0, 18'sd65536, 16'hFFFF, 8'd64, 16'h39E7};
        vt[3]  = '{18'sd0, 18'sd0, 18'sd32768, 18'sd0, 18'sd0, 18'sd65536, 16'hFFFF, 8'd0, 16'h7BEF};
        vt[4]  = '{18'sd0, 18'sd0, 18'sd32768, 18'sd0, 18'sd0, 18'sd65536, 16'hFFFF, 8'd200, 16'hFFFF};
        vt[5]  = '{18'sd65536, 18'sd0, 18'sd0, 18'sd65536, 18'sd0, 18'sd0, 16'h1234, 8'd0, 16'h1234};
        vt[6]  = '{18'sd0, 18'sd0, 18'sd16384, 18'sd0, 18'sd0, 18'sd65536, 16'hF800, 8'd0, 16'h3800};
        vt[7]  = '{18'sd32768, 18'sd32768, 18'sd0, 18'sd32768, 18'sd32768, 18'sd0, 16'h07E0, 8'd10, 16'h0420};
        vt[8]  = '{-18'sd65536, 18'sd0, 18'sd0, -18'sd65536, 18'sd0, 18'sd0, 16'hABCD, 8'd0, 16'hABCD};
        vt[9]  = '{18'sd0, 18'sd0, 18'sd65535, 18'sd0, 18'sd0, 18'sd65536, 16'hFFFF, 8'd0, 16'hF7DE};
        vt[10] = '{18'sd0, 18'sd0, -18'sd65536, 18'sd0, 18'sd0, 18'sd65536, 16'hFFFF, 8'd255, 16'hF7DE};

        reset     = 1'b1;
        start     = 1'b0;
        num_tris  = '0;
        light_dir = '0;
        ambient   = '0;
        clear_obs();
        repeat (3) @(negedge clock);
        #1;
        check("rst busy", int'(busy), 0);
        check("rst done", int'(done), 0);
        check("rst read_addr", int'(read_addr), 0);
        check("rst shade_we", int'(shade_we), 0);
        check("rst shade_addr", int'(shade_addr), 0);
        check("rst shade_data", int'(shade_data), 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        for (int v = 0; v < 11; v++) begin
            mnx[0]  = vt[v].nx;
            mny[0]  = vt[v].ny;
            mnz[0]  = vt[v].nz;
            mcol[0] = vt[v].col;
            start_pass(1, vt[v].lx, vt[v].ly, vt[v].lz, int'(vt[v].amb));
            wait_done(50);
            verify($sformatf("vec%0d", v), 1, 1'b1, int'(vt[v].exp));
        end

        // empty pass
        start_pass(0, 18'sd0, 18'sd0, 18'sd65536, 0);
        wait_done(50);
        verify("n0", 0, 1'b0, 0);

        // second start mid-pass must be ignored
        fill_random(20);
        start_pass(20, 18'sd37837, 18'sd37837, 18'sd37837, 40);
        repeat (3) @(negedge clock);
        @(negedge clock);
        num_tris = 13'd3;
        start    = 1'b1;
        @(negedge clock);
        start    = 1'b0;
        wait_done(100);
        verify("restart", 20, 1'b0, 0);

        // full-depth pass
        fill_random(4096);
        start_pass(4096, 18'sd37837, -18'sd37837, 18'sd37837, 30);
        wait_done(5000);
        verify("n4096", 4096, 1'b0, 0);

        // reset in cycle 3 of an N=10 pass
        fill_random(10);
        start_pass(10, 18'sd0, 18'sd46341, 18'sd46341, 20);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        clear_obs();
        @(negedge clock);
        reset = 1'b0;
        repeat (20) @(negedge clock);
        #1;
        check("rstpass writes", wr_addr.size(), 0);
        check("rstpass busy_cnt", busy_cnt, 0);
        check("rstpass done_cnt", done_cnt, 0);

        start_pass(10, 18'sd0, 18'sd46341, 18'sd46341, 20);
        wait_done(100);
        verify("after_rst", 10, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
